// File: rtl/bench_result_uart.sv
// Captures the four benchmark cycle counts on start and reports them over UART
// (8N1, LSB first) as "C<n>=HHHHHHHH\r\n" lines. Define BENCH_RESULT_WINNER_EN to append "W=<n>\r\n".
module bench_result_uart #(
  parameter int CLK_HZ = 125000000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] t_cond0,
  input  logic [31:0] t_cond1,
  input  logic [31:0] t_cond2,
  input  logic [31:0] t_cond3,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

`ifdef BENCH_RESULT_WINNER_EN
  localparam logic [5:0] LAST_IDX = 6'd56;
`else
  localparam logic [5:0] LAST_IDX = 6'd51;
`endif

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'd0, nib};
    end else begin
      return 8'h37 + {4'd0, nib};
    end
  endfunction

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [5:0]       byte_idx_q, byte_idx_d;
  logic [31:0]      t0_q, t0_d, t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
  logic             tx_q, tx_d, busy_q, busy_d, done_q, done_d;

  logic [2:0]  line_s;
  logic [3:0]  pos_s;
  logic [31:0] cond_val_s;
  logic [3:0]  nib_s;
  logic [7:0]  char_s;
  logic        wrap_s;

  assign line_s = 3'(byte_idx_q / 6'd13);
  assign pos_s  = 4'(byte_idx_q - (6'(line_s) * 6'd13));
  assign wrap_s = (cnt_q == CNT_LAST);

`ifdef BENCH_RESULT_WINNER_EN
  function automatic logic [1:0] min_index(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
    logic [31:0] m;
    logic [1:0]  idx;
    m = a;
    idx = 2'd0;
    if (b < m) begin m = b; idx = 2'd1; end else begin idx = idx; end
    if (c < m) begin m = c; idx = 2'd2; end else begin idx = idx; end
    if (d < m) begin idx = 2'd3; end else begin idx = idx; end
    return idx;
  endfunction

  logic [1:0] winner_s;

  // Smallest latched count, ties to the lowest index
  always_comb begin
    winner_s = min_index(t0_q, t1_q, t2_q, t3_q);
  end
`endif

  // Character for the current byte index, derived from line and column
  always_comb begin
    cond_val_s = 32'd0;
    nib_s      = 4'd0;
    char_s     = 8'h20;
    case (line_s)
      3'd0:    cond_val_s = t0_q;
      3'd1:    cond_val_s = t1_q;
      3'd2:    cond_val_s = t2_q;
      3'd3:    cond_val_s = t3_q;
      default: cond_val_s = 32'd0;
    endcase
    case (pos_s)
      4'd3:    nib_s = cond_val_s[31:28];
      4'd4:    nib_s = cond_val_s[27:24];
      4'd5:    nib_s = cond_val_s[23:20];
      4'd6:    nib_s = cond_val_s[19:16];
      4'd7:    nib_s = cond_val_s[15:12];
      4'd8:    nib_s = cond_val_s[11:8];
      4'd9:    nib_s = cond_val_s[7:4];
      4'd10:   nib_s = cond_val_s[3:0];
      default: nib_s = 4'd0;
    endcase
    if (line_s < 3'd4) begin
      case (pos_s)
        4'd0:    char_s = 8'h43;
        4'd1:    char_s = 8'h30 + {5'd0, line_s};
        4'd2:    char_s = 8'h3D;
        4'd11:   char_s = 8'h0D;
        4'd12:   char_s = 8'h0A;
        default: char_s = hex_ascii(nib_s);
      endcase
    end else begin
`ifdef BENCH_RESULT_WINNER_EN
      case (pos_s)
        4'd0:    char_s = 8'h57;
        4'd1:    char_s = 8'h3D;
        4'd2:    char_s = 8'h30 + {6'd0, winner_s};
        4'd3:    char_s = 8'h0D;
        4'd4:    char_s = 8'h0A;
        default: char_s = 8'h20;
      endcase
`else
      char_s = 8'h20;
`endif
    end
  end

  // Transmit sequencer; every bit-level transition waits for the bit-period wrap
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    t0_d = t0_q; t1_d = t1_q; t2_d = t2_q; t3_d = t3_q;
    tx_d   = tx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          state_d    = ST_START;
          t0_d = t_cond0; t1_d = t_cond1; t2_d = t_cond2; t3_d = t_cond3;
          byte_idx_d = 6'd0;
          bit_idx_d  = 3'd0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (wrap_s) begin
          cnt_d     = '0;
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
          tx_d      = char_s[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (wrap_s) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = char_s[bit_idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (wrap_s) begin
          cnt_d = '0;
          if (byte_idx_q == LAST_IDX) begin
            state_d = ST_FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 6'd1;
            state_d    = ST_START;
            tx_d       = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FIN: begin
        state_d    = ST_IDLE;
        byte_idx_d = 6'd0;
        bit_idx_d  = 3'd0;
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 6'd0;
      t0_q <= 32'd0; t1_q <= 32'd0; t2_q <= 32'd0; t3_q <= 32'd0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      t0_q <= t0_d; t1_q <= t1_d; t2_q <= t2_d; t3_q <= t3_d;
      tx_q   <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign uart_tx = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bench_result_uart.sv
// Bench for bench_result_uart: UART receiver decodes the pin, table vectors plus
// random reports checked against a string-formatting reference model.
module tb_bench_result_uart;

  localparam int CPB      = 8;
  localparam int NBYTES   = 52;
  localparam int BUSY_EXP = NBYTES * 10 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] t_cond0 = 32'd0, t_cond1 = 32'd0, t_cond2 = 32'd0, t_cond3 = 32'd0;
  logic        uart_tx, busy, done;

  bench_result_uart #(.CLK_HZ(8), .BAUD(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .t_cond0(t_cond0), .t_cond1(t_cond1), .t_cond2(t_cond2), .t_cond3(t_cond3),
    .uart_tx(uart_tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntotal = 0;

  // Receiver state, written only by the receiver block
  logic [7:0] rx_q[$];
  int         rx_cnt = 0;
  logic       rx_active = 1'b0;
  logic [7:0] rx_shift = 8'd0;
  int         frame_err = 0;
  int         done_cnt = 0;

  // Bench UART receiver: detects start bits and samples each bit mid-period
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (rst) begin
      rx_active <= 1'b0;
      rx_cnt    <= 0;
    end else if (!rx_active) begin
      if (uart_tx === 1'b0) begin
        rx_active <= 1'b1;
        rx_cnt    <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt % CPB == CPB / 2) begin
        if (rx_cnt / CPB == 0) begin
          if (uart_tx !== 1'b0) begin
            rx_active <= 1'b0;
            frame_err <= frame_err + 1;
          end
        end else if (rx_cnt / CPB <= 8) begin
          rx_shift[rx_cnt / CPB - 1] <= uart_tx;
        end else begin
          rx_active <= 1'b0;
          if (uart_tx === 1'b1) rx_q.push_back(rx_shift);
          else frame_err <= frame_err + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: the report text produced by ordinary string formatting
  function automatic logic [415:0] model_msg(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c, input logic [31:0] d);
    string s;
    logic [415:0] m;
    s = $sformatf("C0=%h\015\012C1=%h\015\012C2=%h\015\012C3=%h\015\012", a, b, c, d);
    s = s.toupper();
    m = '0;
    for (int i = 0; i < NBYTES; i++) m[(NBYTES-1-i)*8 +: 8] = s[i];
    return m;
  endfunction

  task automatic run_report(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                            input logic [31:0] d, input int ovl, input logic [415:0] exp,
                            input string name);
    int base, dbase, fbase, busy_cycles, bad, first_bad;
    logic got;
    base  = rx_q.size();
    dbase = done_cnt;
    fbase = frame_err;
    @(posedge clk); #1;
    chk({name, "_pre_idle"}, {done, busy}, 2'b00);
    t_cond0 = a; t_cond1 = b; t_cond2 = c; t_cond3 = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, "_accept"}, {busy, uart_tx}, 2'b10);
    busy_cycles = 1;
    got = 1'b0;
    for (int cyc = 0; cyc < 6000 && !got; cyc++) begin
      if (ovl != 0 && busy_cycles == ovl) begin
        start = 1'b1;
        t_cond0 = $urandom; t_cond1 = $urandom; t_cond2 = $urandom; t_cond3 = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done === 1'b1) got = 1'b1;
      else if (busy === 1'b1) busy_cycles++;
    end
    start = 1'b0;
    chk({name, "_done_seen"}, got, 1'b1);
    chk({name, "_busy_cycles"}, busy_cycles, BUSY_EXP);
    chk({name, "_busy_low_at_done"}, busy, 1'b0);
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < NBYTES; i++) begin
      if (base + i >= rx_q.size()) begin
        bad++;
      end else if (rx_q[base + i] !== exp[(NBYTES-1-i)*8 +: 8]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    if (first_bad >= 0)
      $display("  %s byte %0d got %h want %h", name, first_bad, rx_q[base + first_bad],
               exp[(NBYTES-1-first_bad)*8 +: 8]);
    chk({name, "_byte_count"}, rx_q.size() - base, NBYTES);
    chk({name, "_msg_bad_bytes"}, bad, 0);
    @(negedge clk); #1;
    chk({name, "_done_pulses"}, done_cnt - dbase, 1);
    chk({name, "_frame_errs"}, frame_err - fbase, 0);
  endtask

  typedef struct {
    logic [31:0]  t0, t1, t2, t3;
    int           ovl;
    logic [415:0] exp;
  } vec_t;

  vec_t tbl[3];

  initial begin
    int lows, dbase;
    logic [31:0] r0, r1, r2, r3;

    tbl[0].t0 = 32'h0000001A; tbl[0].t1 = 32'hDEADBEEF; tbl[0].t2 = 32'h00000000;
    tbl[0].t3 = 32'hFFFFFFFF; tbl[0].ovl = 0;
    tbl[0].exp = "C0=0000001A\015\012C1=DEADBEEF\015\012C2=00000000\015\012C3=FFFFFFFF\015\012";
    tbl[1] = tbl[0];
    tbl[1].ovl = 100;
    tbl[2].t0 = 32'h01234567; tbl[2].t1 = 32'h89ABCDEF; tbl[2].t2 = 32'h0000A5C3;
    tbl[2].t3 = 32'h7FFFFFFE; tbl[2].ovl = 0;
    tbl[2].exp = "C0=01234567\015\012C1=89ABCDEF\015\012C2=0000A5C3\015\012C3=7FFFFFFE\015\012";

    // Reset and quiet line
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", uart_tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    rst = 1'b0;
    lows = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) lows++;
    end
    chk("idle_quiet", lows, 0);

    // Table vectors, issued back-to-back (each start on the cycle after done)
    for (int v = 0; v < 3; v++)
      run_report(tbl[v].t0, tbl[v].t1, tbl[v].t2, tbl[v].t3, tbl[v].ovl, tbl[v].exp,
                 $sformatf("tbl%0d", v));

    // Random reports against the model
    for (int k = 0; k < 3; k++) begin
      r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
      if (k == 1) r2 = 32'd0;
      run_report(r0, r1, r2, r3, (k == 2) ? 37 : 0, model_msg(r0, r1, r2, r3),
                 $sformatf("rnd%0d", k));
    end

    // Reset during a data bit of byte 20
    dbase = done_cnt;
    @(posedge clk); #1;
    t_cond0 = $urandom; t_cond1 = $urandom; t_cond2 = $urandom; t_cond3 = $urandom;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20 * 10 * CPB + 30 - 1) @(posedge clk);
    #1;
    chk("midrst_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_tx", uart_tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    rst = 1'b0;
    lows = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (uart_tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk("midrst_quiet", lows, 0);
    chk("midrst_no_done", done_cnt - dbase, 0);

    r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
    run_report(r0, r1, r2, r3, 0, model_msg(r0, r1, r2, r3), "after_rst");

    @(posedge clk); #1;
    chk("final_idle", {busy, done, uart_tx}, 3'b001);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/bench_result_uart.md
# bench_result_uart

Downstream reporting stage for the benchmark engine. It captures the four 32-bit per-condition cycle counts (`t_cond0..3`) when a benchmark run completes and transmits them as ASCII hex lines over a UART TX pin. This makes the results readable on a host terminal, alongside the one-hot LED winner display. It sits in the top level between the benchmark engine's timing outputs and the board's UART TX pin.

## Interface
Parameters:
- `CLK_HZ`, 125000000, clock frequency in Hz.
- `BAUD`, 115200, serial bit rate.
  - Bit period `CLKS_PER_BIT = CLK_HZ / BAUD` (integer division).
  - Must be ≥ 2.

Ports:
- `clk  in  1`  system clock. One clock domain only.
- `rst  in  1`  reset. Synchronous and active-high.
- `start  in  1`  single-cycle pulse from the benchmark engine meaning "results valid".
- `t_cond0  in  32`  cycle count for condition 0 (all base2).
- `t_cond1  in  32`  cycle count for condition 1 (all base10).
- `t_cond2  in  32`  cycle count for condition 2 (all base12).
- `t_cond3  in  32`  cycle count for condition 3 (router).
- `uart_tx  out  1`  serial output. 8N1 framing, LSB first, idle high.
- `busy  out  1`  high while a report is being transmitted.
- `done  out  1`  one-cycle pulse when the report finishes.

## Operation
- Snapshot:
  - `start` is sampled while `busy=0`.
  - On that edge, `t_cond0..3` are latched into internal registers.
  - Later changes on the inputs have no effect on the report in progress.
- `start` while `busy=1` is ignored. It is not queued.
- Message: four lines, each `C<n>=HHHHHHHH\r\n`.
  - `n` is the ASCII digit 0–3.
  - `HHHHHHHH` is the 8 hex digits of `t_cond<n>`, uppercase (`0-9`, `A-F`), most significant nibble first.
  - Each line is 13 bytes; the full message is 52 bytes.
- Character generation: combinational from a byte index (0..51, or 0..56 with the configuration option below) and the latched values. No ROM is required.
- State machine:
  - IDLE: `uart_tx=1`. On `start`, go to START.
  - START: drive 0 for one bit period, then go to DATA.
  - DATA: drive 8 bits, LSB first, one bit period each, then go to STOP.
  - STOP: drive 1 for one bit period.
    - If the byte index is the last index, go to FIN.
    - Otherwise, increment the byte index and go to START.
  - FIN: lasts one cycle. Pulse `done` and return to IDLE.
- Bytes are sent back-to-back, with no idle gap between the stop bit and the next start bit.
- Counters:
  - Bit-period counter counts 0..`CLKS_PER_BIT`-1 and wraps.
  - Bit index: 3 bits.
  - Byte index: 6 bits.
  - Every state transition happens on the wrap of the bit-period counter.

## Timing
- Reset values: `uart_tx=1`, `busy=0`, `done=0`. All counters are 0 and the state is IDLE.
- All outputs are registered.
- Start acceptance: on the edge that samples `start`, `busy` becomes 1 and `uart_tx` becomes 0 (start bit of byte 0) in the same cycle.
- Each bit is held for exactly `CLKS_PER_BIT` cycles.
- Total `busy` time: 52 × 10 × `CLKS_PER_BIT` cycles, followed by 1 FIN cycle.
  - At 125 MHz / 115200 baud, `CLKS_PER_BIT` = 1085, so the message takes 564,200 cycles.
- `done` is high for exactly one cycle (FIN) and `busy` drops on that same edge.
- A new `start` is accepted on the cycle after `done`.
- Reset in the middle of a transmission aborts it on the next edge:
  - `uart_tx=1`, `busy=0`, and no `done` pulse.
  - The latched values are don't-care.
- If `rst` and `start` are high on the same edge, `rst` wins.

## Configuration
- `BENCH_RESULT_WINNER_EN`
  - Defined: a fifth line `W=<n>\r\n` (5 bytes) is appended, for a 57-byte message.
    - `n` is the index of the smallest latched count.
    - Ties resolve to the lowest index.
    - The comparison is computed combinationally from the latched values. It must be complete before byte 52 is sent.
  - Undefined: the message is the four lines only (52 bytes), and no comparator logic is synthesized.

## Test plan
For all cases, use `CLK_HZ=8`, `BAUD=1` (8 cycles per bit) and decode `uart_tx` with a bench UART receiver.

1. Reset: hold `rst` for 3 cycles → `uart_tx=1`, `busy=0`, `done=0`. With no `start`, `uart_tx` stays 1 for 1000 cycles.
2. Basic report:
   - Stimulus: `t_cond0`=0x0000001A, `t_cond1`=0xDEADBEEF, `t_cond2`=0, `t_cond3`=0xFFFFFFFF, then a `start` pulse.
   - Required response: the receiver decodes `"C0=0000001A\r\nC1=DEADBEEF\r\nC2=00000000\r\nC3=FFFFFFFF\r\n"`.
   - `busy` stays high for 4160 cycles, then `done` pulses exactly once.
3. Snapshot and overlap:
   - Stimulus: change all `t_cond` inputs and pulse `start` again, 100 cycles after the first `start`.
   - Required response: the output is identical to the first report, and there is only one `done` pulse.
4. Mid-frame reset:
   - Stimulus: assert `rst` during byte 20 (a DATA bit).
   - Required response: `uart_tx=1` and `busy=0` on the next edge, with no `done` pulse. A subsequent `start` produces a complete, correct message.
5. Back-to-back runs: a `start` pulse on the cycle after `done` is accepted, and `busy` rises immediately.
6. Winner line (with `BENCH_RESULT_WINNER_EN` defined):
   - Counts 50, 30, 30, 90 → last line `"W=1\r\n"`.
   - Counts all equal → last line `"W=0\r\n"`.
   - Total `busy` time is 4560 cycles.
